// File: rtl/eei.sv
// Shared environment definitions for the ACLINT block: register offsets,
// the bus FSM state type and the byte-lane write merge helper.
package eei;

  typedef logic [63:0] UInt64;

  localparam logic [15:0] ACLINT_MSIP_OFFSET     = 16'h0000;
  localparam logic [15:0] ACLINT_MTIMECMP_OFFSET = 16'h4000;
  localparam logic [15:0] ACLINT_MTIME_OFFSET    = 16'hbff8;

  typedef enum logic {
    ACLINT_IDLE,
    ACLINT_RESP
  } aclint_state_e;

  // Each wmask bit selects one byte lane of wdata; unselected lanes keep old_value.
  function automatic UInt64 apply_wmask(UInt64 old_value, UInt64 wdata, logic [7:0] wmask);
    UInt64 lane_mask;
    for (int i = 0; i < 8; i++) begin
      lane_mask[i*8 +: 8] = {8{wmask[i]}};
    end
    return (wdata & lane_mask) | (old_value & ~lane_mask);
  endfunction

endpackage

// File: rtl/aclint_if.sv
// Timer and software-interrupt lines from the ACLINT device to the core's CSR unit.
interface aclint_if;
  import eei::*;

  logic  mtip;
  logic  msip;
  UInt64 mtime;

  modport master (output mtip, output msip, output mtime);
  modport slave  (input  mtip, input  msip, input  mtime);

endinterface

// File: rtl/aclint_timer.sv
// Free-running mtime counter with a TICK_DIV prescaler; a bus write to mtime
// takes priority over the tick and restarts the prescaler period.
module aclint_timer
  import eei::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wen,
  input  UInt64      wdata,
  input  logic [7:0] wmask,
  output UInt64      mtime
);

  localparam int                DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= '0;
      div   <= '0;
    end else if (wen) begin
      mtime <= apply_wmask(mtime, wdata, wmask);
      div   <= '0;
    end else if (div == DIV_LAST) begin
      mtime <= mtime + 64'd1;
      div   <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/aclint_memory.sv
// Memory-mapped ACLINT: single-outstanding bus port onto MSIP, MTIMECMP and MTIME,
// driving mtip/msip/mtime to the core over aclint_if.
module aclint_memory
  import eei::*;
#(
  parameter int TICK_DIV   = 1,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_valid,
  output logic                  bus_ready,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  bus_wen,
  input  UInt64                 bus_wdata,
  input  logic [7:0]            bus_wmask,
  output logic                  bus_rvalid,
  output UInt64                 bus_rdata,
  aclint_if.master              aclint
);

  localparam logic [ADDR_WIDTH-1:0] MSIP_ADDR     = ADDR_WIDTH'(ACLINT_MSIP_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] MTIMECMP_ADDR = ADDR_WIDTH'(ACLINT_MTIMECMP_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] MTIME_ADDR    = ADDR_WIDTH'(ACLINT_MTIME_OFFSET);

  aclint_state_e state;
  logic          msip;
  UInt64         mtimecmp;
  UInt64         mtime;
  UInt64         read_value;
  logic          accept;
  logic          sel_msip;
  logic          sel_mtimecmp;
  logic          sel_mtime;
  logic          mtime_wen;
  logic          unused_addr_bits;

  // Registers are 64-bit aligned, so the byte offset within a word never matters.
  assign unused_addr_bits = ^bus_addr[2:0];

  assign accept       = bus_valid && bus_ready;
  assign sel_msip     = (bus_addr[ADDR_WIDTH-1:3] == MSIP_ADDR[ADDR_WIDTH-1:3]);
  assign sel_mtimecmp = (bus_addr[ADDR_WIDTH-1:3] == MTIMECMP_ADDR[ADDR_WIDTH-1:3]);
  assign sel_mtime    = (bus_addr[ADDR_WIDTH-1:3] == MTIME_ADDR[ADDR_WIDTH-1:3]);
  assign mtime_wen    = accept && bus_wen && sel_mtime;

  always_comb begin
    read_value = '0;
    if (sel_msip) begin
      read_value = {63'd0, msip};
    end else if (sel_mtimecmp) begin
      read_value = mtimecmp;
    end else if (sel_mtime) begin
      read_value = mtime;
    end
  end

  aclint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .wen   (mtime_wen),
    .wdata (bus_wdata),
    .wmask (bus_wmask),
    .mtime (mtime)
  );

  // One response cycle per accepted request; no back-pressure on the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACLINT_IDLE;
      bus_ready  <= 1'b1;
      bus_rvalid <= 1'b0;
      bus_rdata  <= '0;
    end else begin
      case (state)
        ACLINT_IDLE: begin
          if (accept) begin
            bus_rdata  <= read_value;
            state      <= ACLINT_RESP;
            bus_ready  <= 1'b0;
            bus_rvalid <= 1'b1;
          end
        end
        ACLINT_RESP: begin
          state      <= ACLINT_IDLE;
          bus_ready  <= 1'b1;
          bus_rvalid <= 1'b0;
        end
        default: begin
          state      <= ACLINT_IDLE;
          bus_ready  <= 1'b1;
          bus_rvalid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      msip     <= 1'b0;
      mtimecmp <= '1;
    end else if (accept && bus_wen) begin
      if (sel_msip && bus_wmask[0]) begin
        msip <= bus_wdata[0];
      end
      if (sel_mtimecmp) begin
        mtimecmp <= apply_wmask(mtimecmp, bus_wdata, bus_wmask);
      end
    end
  end

  assign aclint.mtip  = (mtime >= mtimecmp);
  assign aclint.msip  = msip;
  assign aclint.mtime = mtime;

endmodule

// File: tb/tb_aclint_memory.sv
// Self-checking bench for aclint_memory: register table, timer compare, wrap,
// byte masking, back-to-back requests, reset during RESP and TICK_DIV = 4.
module tb_aclint_memory;
  import eei::*;

  typedef struct {
    logic        wen;
    logic [15:0] addr;
    UInt64       wdata;
    logic [7:0]  wmask;
    UInt64       rdata;
    logic        msip;
  } vec_t;

  typedef struct packed {
    logic  chk;
    UInt64 data;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        bus_valid;
  logic        bus_ready;
  logic [15:0] bus_addr;
  logic        bus_wen;
  UInt64       bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_rvalid;
  UInt64       bus_rdata;

  logic        bus4_valid;
  logic        bus4_ready;
  logic [15:0] bus4_addr;
  logic        bus4_wen;
  UInt64       bus4_wdata;
  logic [7:0]  bus4_wmask;
  logic        bus4_rvalid;
  UInt64       bus4_rdata;

  int   checks = 0;
  int   errors = 0;
  int   sb_idx = 0;
  sb_t  sb_q[$];
  sb_t  mon_entry;
  vec_t vecs[14];

  aclint_if aclint1 ();
  aclint_if aclint4 ();

  aclint_memory #(.TICK_DIV(1), .ADDR_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_valid  (bus_valid),
    .bus_ready  (bus_ready),
    .bus_addr   (bus_addr),
    .bus_wen    (bus_wen),
    .bus_wdata  (bus_wdata),
    .bus_wmask  (bus_wmask),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .aclint     (aclint1)
  );

  aclint_memory #(.TICK_DIV(4), .ADDR_WIDTH(16)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .bus_valid  (bus4_valid),
    .bus_ready  (bus4_ready),
    .bus_addr   (bus4_addr),
    .bus_wen    (bus4_wen),
    .bus_wdata  (bus4_wdata),
    .bus_wmask  (bus4_wmask),
    .bus_rvalid (bus4_rvalid),
    .bus_rdata  (bus4_rdata),
    .aclint     (aclint4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input UInt64 actual, input UInt64 expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Issue one request, record its expected response, and return at the negedge after accept.
  task automatic applyStimulus(input logic wen, input logic [15:0] addr, input UInt64 wdata,
                               input logic [7:0] wmask, input logic chk, input UInt64 exp);
    int wait_cnt = 0;
    bus_wen   = wen;
    bus_addr  = addr;
    bus_wdata = wdata;
    bus_wmask = wmask;
    bus_valid = 1'b1;
    while (!bus_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!bus_ready) begin
      checkOutput("ready_timeout", 64'(bus_ready), 64'd1);
      bus_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back('{chk, exp});
    #1 bus_valid = 1'b0;
    @(negedge clk);
    checkOutput("rvalid_latency", 64'(bus_rvalid), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && bus_rvalid) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_rvalid", 64'(bus_rvalid), 64'd0);
      end else begin
        mon_entry = sb_q.pop_front();
        if (mon_entry.chk) begin
          checkOutput($sformatf("sb_rdata%0d", sb_idx), bus_rdata, mon_entry.data);
        end
        sb_idx++;
      end
    end
  end

  initial begin
    rst        = 1'b1;
    bus_valid  = 1'b0;
    bus_addr   = '0;
    bus_wen    = 1'b0;
    bus_wdata  = '0;
    bus_wmask  = '0;
    bus4_valid = 1'b0;
    bus4_addr  = '0;
    bus4_wen   = 1'b0;
    bus4_wdata = '0;
    bus4_wmask = '0;

    vecs[0]  = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'hffff_ffff_ffff_ffff, 1'b0};
    vecs[1]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0000, 64'h1, 8'h01, 64'h0, 1'b1};
    vecs[3]  = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h1, 1'b1};
    vecs[4]  = '{1'b1, 16'h0000, 64'h0, 8'h00, 64'h0, 1'b1};
    vecs[5]  = '{1'b0, 16'h0004, 64'h0, 8'h00, 64'h1, 1'b1};
    vecs[6]  = '{1'b1, 16'h1000, 64'h55, 8'hff, 64'h0, 1'b1};
    vecs[7]  = '{1'b0, 16'h1000, 64'h0, 8'h00, 64'h0, 1'b1};
    vecs[8]  = '{1'b1, 16'h4000, 64'h0123_4567_89ab_cdef, 8'hff, 64'h0, 1'b1};
    vecs[9]  = '{1'b0, 16'h4004, 64'h0, 8'h00, 64'h0123_4567_89ab_cdef, 1'b1};
    vecs[10] = '{1'b1, 16'h4000, 64'h0, 8'h0f, 64'h0, 1'b1};
    vecs[11] = '{1'b0, 16'h4000, 64'h0, 8'h00, 64'h0123_4567_0000_0000, 1'b1};
    vecs[12] = '{1'b1, 16'h0000, 64'h0, 8'h01, 64'h0, 1'b0};
    vecs[13] = '{1'b0, 16'h0000, 64'h0, 8'h00, 64'h0, 1'b0};

    @(negedge clk);
    checkOutput("rst_ready", 64'(bus_ready), 64'd1);
    checkOutput("rst_rvalid", 64'(bus_rvalid), 64'd0);
    checkOutput("rst_rdata", bus_rdata, 64'd0);
    checkOutput("rst_mtime", aclint1.mtime, 64'd0);
    checkOutput("rst_msip", 64'(aclint1.msip), 64'd0);
    checkOutput("rst_mtip", 64'(aclint1.mtip), 64'd0);
    bus_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_no_accept", 64'(bus_rvalid), 64'd0);
    bus_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wmask,
                    !vecs[i].wen, vecs[i].rdata);
      checkOutput($sformatf("vec%0d_msip", i), 64'(aclint1.msip), 64'(vecs[i].msip));
      checkOutput($sformatf("vec%0d_mtip", i), 64'(aclint1.mtip), 64'd0);
    end

    applyStimulus(1'b1, 16'h4000, 64'd105, 8'hff, 1'b0, 64'd0);
    applyStimulus(1'b1, 16'hbff8, 64'd100, 8'hff, 1'b0, 64'd0);
    checkOutput("mtime_write", aclint1.mtime, 64'd100);
    checkOutput("mtip_k0", 64'(aclint1.mtip), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("mtip_k%0d", k), 64'(aclint1.mtip), 64'(k == 5));
    end
    checkOutput("mtime_105", aclint1.mtime, 64'd105);
    applyStimulus(1'b1, 16'h4000, 64'hffff_ffff_ffff_ffff, 8'hff, 1'b0, 64'd0);
    checkOutput("mtip_clear", 64'(aclint1.mtip), 64'd0);

    applyStimulus(1'b1, 16'hbff8, 64'hffff_ffff_ffff_fffe, 8'hff, 1'b0, 64'd0);
    checkOutput("wrap_fe", aclint1.mtime, 64'hffff_ffff_ffff_fffe);
    @(negedge clk);
    checkOutput("wrap_ff", aclint1.mtime, 64'hffff_ffff_ffff_ffff);
    @(negedge clk);
    checkOutput("wrap_0", aclint1.mtime, 64'd0);
    applyStimulus(1'b0, 16'hbff8, 64'd0, 8'h00, 1'b1, 64'd0);
    applyStimulus(1'b1, 16'hbff8, 64'h0000_0000_1200_0000, 8'h08, 1'b0, 64'd0);
    checkOutput("mtime_lane3", aclint1.mtime, 64'h0000_0000_1200_0002);
    applyStimulus(1'b1, 16'h4000, 64'h0000_0000_1200_0000, 8'h08, 1'b0, 64'd0);
    applyStimulus(1'b0, 16'h4000, 64'd0, 8'h00, 1'b1, 64'hffff_ffff_12ff_ffff);

    bus_wen  = 1'b0;
    bus_addr = 16'h1000;
    @(negedge clk);
    checkOutput("b2b_ready0", 64'(bus_ready), 64'd1);
    sb_q.push_back('{1'b1, 64'd0});
    bus_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_rvalid%0d", i), 64'(bus_rvalid), 64'(i % 2 == 1));
      checkOutput($sformatf("b2b_ready%0d", i), 64'(bus_ready), 64'(i % 2 == 0));
      if (i < 5 && bus_ready) begin
        sb_q.push_back('{1'b1, 64'd0});
      end
    end
    bus_valid = 1'b0;

    applyStimulus(1'b1, 16'h0000, 64'h1, 8'h01, 1'b0, 64'd0);
    checkOutput("msip_before_rst", 64'(aclint1.msip), 64'd1);
    @(negedge clk);
    bus_wen   = 1'b0;
    bus_addr  = 16'h4000;
    bus_valid = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b1;
    bus_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_rvalid", 64'(bus_rvalid), 64'd0);
    checkOutput("abort_ready", 64'(bus_ready), 64'd1);
    checkOutput("abort_msip", 64'(aclint1.msip), 64'd0);
    checkOutput("abort_mtime", aclint1.mtime, 64'd0);
    checkOutput("abort_rdata", bus_rdata, 64'd0);
    @(negedge clk);
    checkOutput("abort_rvalid2", 64'(bus_rvalid), 64'd0);
    rst = 1'b0;

    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tick1_k%0d", k), aclint1.mtime, 64'(k));
      checkOutput($sformatf("tick4_k%0d", k), aclint4.mtime, 64'(k / 4));
    end
    bus4_wen   = 1'b1;
    bus4_addr  = 16'hbff8;
    bus4_wdata = 64'd500;
    bus4_wmask = 8'hff;
    bus4_valid = 1'b1;
    @(posedge clk);
    #1 bus4_valid = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      checkOutput($sformatf("tick4_wr_j%0d", j), aclint4.mtime, 64'(500 + (j - 1) / 4));
    end

    applyStimulus(1'b0, 16'h4000, 64'd0, 8'h00, 1'b1, 64'hffff_ffff_ffff_ffff);
    checkOutput("post_rst_mtip", 64'(aclint1.mtip), 64'd0);
    repeat (3) @(negedge clk);
    checkOutput("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aclint_memory.md
# aclint_memory

Memory-mapped ACLINT device that drives the machine timer and software-interrupt lines consumed by the core's CSR unit over `aclint_if`. It owns the free-running `mtime` counter, the `mtimecmp` compare register and the `msip` bit. All three are reachable through a single-outstanding request/response memory port from the bus interconnect. It sits on the system bus beside RAM and is the master end of `aclint_if`.

## Interface
Parameters:
- `TICK_DIV`, default 1: clock cycles per `mtime` increment; legal range ≥1.
- `ADDR_WIDTH`, default 16: width of the byte offset within the ACLINT window; the interconnect strips the base address.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `bus_valid`  in  1  request valid.
- `bus_ready`  out  1  request accepted when `bus_valid && bus_ready`.
- `bus_addr`  in  ADDR_WIDTH  byte offset.
- `bus_wen`  in  1  1 = write, 0 = read.
- `bus_wdata`  in  64  write data.
- `bus_wmask`  in  8  byte enables for writes.
- `bus_rvalid`  out  1  one-cycle response strobe; issued for reads and writes.
- `bus_rdata`  out  64  read data, valid while `bus_rvalid`.
- `aclint`  `aclint_if.master`  carries `mtip` (1), `msip` (1) and `mtime` (64) to the core.

## Operation
- Register map, decoded on `bus_addr[ADDR_WIDTH-1:3]`. `bus_addr[2:0]` is ignored.
  - 0x0000: MSIP. Bit 0 is R/W and is written only when `bus_wmask[0]`. Bits 63:1 read 0.
  - 0x4000: MTIMECMP. 64-bit R/W.
  - 0xBFF8: MTIME. 64-bit R/W.
  - Any other offset reads 0, ignores writes, and still responds.
- Writes are byte-masked: `new = (wdata & M) | (old & ~M)`, where M expands `bus_wmask` to 8-bit lanes.
- Counter: prescaler `div` counts 0..TICK_DIV-1. `mtime` increments by 1 when `div == TICK_DIV-1`.
  - `mtime` wraps from 2^64-1 to 0 with no flag.
  - A bus write to MTIME in the same cycle as an increment wins: the increment is dropped and `div` clears to 0.
- `aclint.mtip = (mtime >= mtimecmp)`, an unsigned 64-bit compare of the registered values.
- `aclint.msip` = MSIP bit 0. `aclint.mtime` = the `mtime` register.
- FSM, two states:
  - IDLE: `bus_ready` = 1. On accept, perform the write or capture the read data, then go to RESP.
  - RESP: `bus_ready` = 0, `bus_rvalid` = 1. Return to IDLE next cycle unconditionally; there is no response back-pressure.
- Read data is the register value at the accept edge, before any increment applied at that same edge.
- Reset values:
  - FSM in IDLE, `bus_ready` = 1, `bus_rvalid` = 0, `bus_rdata` = 0.
  - `msip` = 0, `mtime` = 0, `div` = 0.
  - `mtimecmp` = all ones, so `mtip` = 0 out of reset.

## Timing
- Accept at edge N. `bus_rvalid` is high in the cycle after edge N. Next accept is possible at edge N+2, giving a maximum throughput of one request per 2 cycles.
- A write becomes visible on `aclint` outputs in the cycle after the accept edge. `mtip` follows in the same cycle because it is combinational from the registers.
- With `TICK_DIV` = 1, `mtime` increments every cycle that is not a MTIME write.
- `bus_rdata` holds its value outside `bus_rvalid`. Verification checks it only when `bus_rvalid` = 1.
- Reset asserted mid-transaction, including in RESP, aborts the transaction. No `bus_rvalid` is issued for it, and all registers take their reset values asynchronously.
- A request present during reset is not accepted. After reset deasserts, acceptance follows the IDLE rules.

## Structure
- Package `eei` holds:
  - `ACLINT_MSIP_OFFSET` = 'h0000
  - `ACLINT_MTIMECMP_OFFSET` = 'h4000
  - `ACLINT_MTIME_OFFSET` = 'hbff8
  - the FSM state enum
- Package `eei` reuses `UInt64`.
- Sub-module `aclint_timer` contains the prescaler plus the `mtime` register. Its inputs are the write enable, write data and byte mask. Its output is `mtime`.
- The top level contains bus decode, the FSM, MSIP, MTIMECMP and the compare.

## Test plan
- Reset, then read MTIMECMP → `bus_rdata` = 'hffff_ffff_ffff_ffff one cycle after accept; `mtip` = 0 and `msip` = 0 throughout.
- Write MSIP = 1 with `wmask` = 'h01 → `aclint.msip` = 1 the cycle after accept. Repeat with `wmask` = 'h00 and data 0 → `msip` stays 1.
- Write MTIME = 100 and MTIMECMP = 105 (`TICK_DIV` = 1) → `mtip` rises exactly 5 cycles after the MTIME write takes effect. Writing MTIMECMP = 'hffff_ffff_ffff_ffff clears `mtip` the next cycle.
- Write MTIME = 'hffff_ffff_ffff_fffe → reads show wrap to 0 two cycles later; byte-masked write of 'h12 into lane 3 only changes bits 31:24.
- `TICK_DIV` = 4: `mtime` increments every 4th cycle. Writing MTIME mid-period restarts the 4-cycle period from the write.
- Back-to-back `bus_valid` held high → accepts on alternate cycles, one `bus_rvalid` per request. Reads of offset 'h1000 return 0. Asserting `rst` during RESP suppresses `bus_rvalid`.
